// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit decoder words,
// flags illegal field sets and streams legal words out through a small FIFO.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               f_cond,
    input  logic [1:0]               f_op,
    input  logic [5:0]               f_funct,
    input  logic [3:0]               f_rn,
    input  logic [3:0]               f_rd,
    input  logic [11:0]              f_src2,
    input  logic [23:0]              f_imm24,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued_count,
    output logic                     err_illegal
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   word;
    logic          s_bit, illegal, accept, push, pop;

    always_comb begin
        // TST/TEQ/CMP/CMN only exist as flag-setting forms
        s_bit     = (f_funct[4:3] == 2'b10) ? 1'b1 : f_funct[0];
        word      = (f_op == 2'b00) ? {f_cond, 2'b00, f_funct[5:1], s_bit, f_rn, f_rd, f_src2} :
                    (f_op == 2'b01) ? {f_cond, 2'b01, f_funct, f_rn, f_rd, f_src2} :
                                      {f_cond, 2'b10, 1'b1, f_funct[4], f_imm24};
        illegal   = (f_op == 2'b11) || (f_cond == 4'hF);
        in_ready  = level < (AW+1)'(DEPTH);
        accept    = in_valid && in_ready;
        push      = accept && !illegal;
        out_valid = level != '0;
        pop       = out_valid && out_ready;
        out_instr = out_valid ? mem[rd_ptr] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            issued_count <= '0;
            err_illegal  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                issued_count <= issued_count + 1'b1;
            end
            level       <= level + (AW+1)'(push) - (AW+1)'(pop);
            err_illegal <= err_illegal | (accept && illegal);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench; expected words are computed from the
// field-packing rules and matched against every output pop.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, err_illegal;
    logic [3:0]  f_cond, f_rn, f_rd;
    logic [1:0]  f_op;
    logic [5:0]  f_funct;
    logic [11:0] f_src2;
    logic [23:0] f_imm24;
    logic [31:0] out_instr;
    logic [2:0]  level;
    logic [15:0] issued_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [15:0] model_issued = '0;
    logic        exp_err = 1'b0;
    logic [15:0] base;

    instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .f_cond(f_cond), .f_op(f_op), .f_funct(f_funct), .f_rn(f_rn), .f_rd(f_rd),
        .f_src2(f_src2), .f_imm24(f_imm24), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .level(level), .issued_count(issued_count),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [3:0] cond, input logic [1:0] op,
                                             input logic [5:0] funct, input logic [3:0] rn,
                                             input logic [3:0] rd, input logic [11:0] src2,
                                             input logic [23:0] imm);
        logic [31:0] c, f, r, d, s, i, cmd, sflag;
        c = {28'b0, cond}; f = {26'b0, funct}; r = {28'b0, rn}; d = {28'b0, rd};
        s = {20'b0, src2}; i = {8'b0, imm};
        cmd = (f / 2) % 16;
        sflag = (cmd >= 8 && cmd <= 11) ? 1 : f % 2;
        if (op == 2'd0)
            return c * 32'h1000_0000 + (f / 2) * 32'h20_0000 + sflag * 32'h10_0000
                   + r * 32'h1_0000 + d * 32'h1000 + s;
        if (op == 2'd1)
            return c * 32'h1000_0000 + 32'h0400_0000 + f * 32'h10_0000
                   + r * 32'h1_0000 + d * 32'h1000 + s;
        return c * 32'h1000_0000 + 32'h0800_0000 + 32'h0200_0000
               + ((f / 16) % 2) * 32'h0100_0000 + i;
    endfunction

    // stimulus-side scoreboard feed
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            if (f_op == 2'd3 || f_cond == 4'hF) exp_err = 1'b1;
            else q.push_back(ref_word(f_cond, f_op, f_funct, f_rn, f_rd, f_src2, f_imm24));
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%h required=none", out_instr);
            end else begin
                check("out_instr", out_instr, q.pop_front());
                model_issued++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] cond, input logic [1:0] op,
                          input logic [5:0] funct, input logic [3:0] rn, input logic [3:0] rd,
                          input logic [11:0] src2, input logic [23:0] imm);
        in_valid = v; f_cond = cond; f_op = op; f_funct = funct;
        f_rn = rn; f_rd = rd; f_src2 = src2; f_imm24 = imm;
    endtask

    task automatic set_rand(input logic v, input bit legal);
        set_in(v, 4'($urandom_range(0, legal ? 14 : 15)), 2'($urandom_range(0, legal ? 2 : 3)),
               6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 24'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        q.delete();
        model_issued = '0;
        exp_err = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_issued"}, 32'(issued_count), 0);
        check({tag, "_err"}, 32'(err_illegal), 0);
        check({tag, "_out_instr"}, out_instr, 0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && level != 0; i++) step();
        check("drain_level", 32'(level), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        set_rand(1'b0, 1'b1);
        step();
        do_reset();
        check_reset_state("reset");

        set_in(1, 4'hD, 2'd0, 6'b110111, 4'h1, 4'h6, 12'hAFF, 24'h0);
        step();
        in_valid = 1'b0;
        check("dp_valid", 32'(out_valid), 1);
        check("dp_word", out_instr, 32'hD3716AFF);
        step();
        set_in(1, 4'hD, 2'd0, 6'b110110, 4'h1, 4'h6, 12'hAFF, 24'h0);
        step();
        in_valid = 1'b0;
        check("dp_forced_s", out_instr, 32'hD3716AFF);
        step();
        set_in(1, 4'h1, 2'd1, 6'b110111, 4'h1, 4'h0, 12'hAEF, 24'h0);
        step();
        in_valid = 1'b0;
        check("mem_word", out_instr, 32'h17710AEF);
        step();
        set_in(1, 4'hD, 2'd2, 6'b010000, 4'h3, 4'h4, 12'h555, 24'h716AE3);
        step();
        in_valid = 1'b0;
        check("br_word", out_instr, 32'hDB716AE3);
        step();

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand(1'b1, 1'b1);
            if (i == 4) check("bp_in_ready_full", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        check("bp_level", 32'(level), 4);
        check("bp_in_ready", 32'(in_ready), 0);
        base = model_issued;
        drain();
        check("bp_issued", 32'(issued_count), 32'(base + 16'd4));
        check("bp_queue_empty", q.size(), 0);

        set_in(1, 4'h2, 2'd3, 6'h3F, 4'h1, 4'h2, 12'h123, 24'h0);
        step();
        set_in(1, 4'hF, 2'd0, 6'b000010, 4'h1, 4'h2, 12'h123, 24'h0);
        step();
        in_valid = 1'b0;
        check("ill_level", 32'(level), 0);
        check("ill_out_valid", 32'(out_valid), 0);
        check("ill_err", 32'(err_illegal), 1);
        set_in(1, 4'hE, 2'd0, 6'b001000, 4'h2, 4'h3, 12'h0F0, 24'h0);
        step();
        in_valid = 1'b0;
        check("ill_then_legal", out_instr, 32'hE0823 << 12 | 32'h0F0);
        drain();
        check("ill_err_sticky", 32'(err_illegal), 1);

        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rand(1'b1, 1'b1);
            step();
            check("stream_level", 32'(level), 1);
        end
        in_valid = 1'b0;
        check("stream_issued", 32'(issued_count), 19);
        drain();

        for (int i = 0; i < 400; i++) begin
            set_rand(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        drain();
        check("rand_issued", 32'(issued_count), 32'(model_issued));
        check("rand_err", 32'(err_illegal), 32'(exp_err));
        check("rand_queue_empty", q.size(), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand(1'b1, 1'b1);
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_level", 32'(level), 3);
        do_reset();
        check_reset_state("midreset");
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
